// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier: one add/sub-and-shift step per clock, full 2*WIDTH product.
// Optional BOOTH_ZERO_SKIP_EN: a zero operand completes in one cycle without entering CALC.
module booth_mul_seq #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int NQ = WIDTH + 1 - SIGNED;
    localparam int CW = $clog2(NQ + 1);
    localparam int AW = WIDTH + 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_t;

    state_t             r_state, w_state_next;
    logic [AW-1:0]      r_a, w_a_next;
    logic [AW-1:0]      r_m, w_m_next;
    logic [NQ-1:0]      r_q, w_q_next;
    logic               r_q1, w_q1_next;
    logic [CW-1:0]      r_cnt, w_cnt_next;
    logic [2*WIDTH-1:0] r_p, w_p_next;
    logic               r_done, w_done_next;

    logic [AW-1:0]      w_ext_y;
    logic [NQ-1:0]      w_ext_x;
    logic [AW-1:0]      w_sum;
    logic [AW-1:0]      w_a_sh;
    logic [NQ-1:0]      w_q_sh;
    logic               w_zero;

    // Unsigned mode widens x by one zero bit so Booth recoding sees a positive multiplier.
    generate
        if (SIGNED != 0) begin : g_signed
            assign w_ext_y = {{2{y[WIDTH-1]}}, y};
            assign w_ext_x = x;
        end else begin : g_unsigned
            assign w_ext_y = {2'b00, y};
            assign w_ext_x = {1'b0, x};
        end
    endgenerate

`ifdef BOOTH_ZERO_SKIP_EN
    assign w_zero = (x == '0) || (y == '0);
`else
    assign w_zero = 1'b0;
`endif

    always_comb begin
        case ({r_q[0], r_q1})
            2'b01:   w_sum = r_a + r_m;
            2'b10:   w_sum = r_a - r_m;
            default: w_sum = r_a;
        endcase
    end

    assign w_a_sh = {w_sum[AW-1], w_sum[AW-1:1]};
    assign w_q_sh = {w_sum[0], r_q[NQ-1:1]};

    always_comb begin
        w_state_next = r_state;
        w_a_next     = r_a;
        w_m_next     = r_m;
        w_q_next     = r_q;
        w_q1_next    = r_q1;
        w_cnt_next   = r_cnt;
        w_p_next     = r_p;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_zero) begin
                        w_p_next    = '0;
                        w_done_next = 1'b1;
                    end else begin
                        w_a_next     = '0;
                        w_m_next     = w_ext_y;
                        w_q_next     = w_ext_x;
                        w_q1_next    = 1'b0;
                        w_cnt_next   = CW'(NQ);
                        w_state_next = S_CALC;
                    end
                end
            end
            S_CALC: begin
                w_a_next   = w_a_sh;
                w_q_next   = w_q_sh;
                w_q1_next  = r_q[0];
                w_cnt_next = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    // Low 2*WIDTH bits of the shifted {A,Q}; the extra A bits are only guard bits.
                    w_p_next     = {w_a_sh[WIDTH-2+SIGNED:0], w_q_sh};
                    w_done_next  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_m     <= '0;
            r_q     <= '0;
            r_q1    <= 1'b0;
            r_cnt   <= '0;
            r_p     <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_a     <= w_a_next;
            r_m     <= w_m_next;
            r_q     <= w_q_next;
            r_q1    <= w_q1_next;
            r_cnt   <= w_cnt_next;
            r_p     <= w_p_next;
            r_done  <= w_done_next;
        end
    end

    assign busy = (r_state == S_CALC);
    assign done = r_done;
    assign p    = r_p;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Bench for booth_mul_seq: signed and unsigned instances, directed corners, handshake/reset cases,
// then random operands checked against plain integer multiplication.
module tb_booth_mul_seq;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_s = 1'b0, start_u = 1'b0;
    logic [W-1:0]  x_s = '0, y_s = '0, x_u = '0, y_u = '0;
    logic          busy_s, done_s, busy_u, done_u;
    logic [2*W-1:0] p_s, p_u;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    booth_mul_seq #(.WIDTH(W), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst(rst), .start(start_s), .x(x_s), .y(y_s),
        .busy(busy_s), .done(done_s), .p(p_s)
    );

    booth_mul_seq #(.WIDTH(W), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst(rst), .start(start_u), .x(x_u), .y(y_u),
        .busy(busy_u), .done(done_u), .p(p_u)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        longint ia, ib, prod;
        ia = sgn ? longint'($signed(a)) : longint'(a);
        ib = sgn ? longint'($signed(b)) : longint'(b);
        prod = ia * ib;
        return prod[2*W-1:0];
    endfunction

    function automatic int ref_busy(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef BOOTH_ZERO_SKIP_EN
        if (a == '0 || b == '0) return 0;
`endif
        return sgn ? W : W + 1;
    endfunction

    function automatic logic get_done(input bit sgn);
        return sgn ? done_s : done_u;
    endfunction

    function automatic logic get_busy(input bit sgn);
        return sgn ? busy_s : busy_u;
    endfunction

    function automatic logic [2*W-1:0] get_p(input bit sgn);
        return sgn ? p_s : p_u;
    endfunction

    // Starting at the current falling edge, count busy samples until done is seen (bounded).
    task automatic wait_done(input bit sgn, output int bc, output bit seen);
        bc = 0;
        seen = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (get_done(sgn)) begin
                seen = 1'b1;
                break;
            end
            if (get_busy(sgn)) bc++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        int bc;
        bit seen;
        logic [2*W-1:0] exp_p;
        exp_p = ref_mul(sgn, a, b);
        @(negedge clk);
        if (sgn) begin start_s = 1'b1; x_s = a; y_s = b; end
        else     begin start_u = 1'b1; x_u = a; y_u = b; end
        @(negedge clk);
        // Scramble operands after the accepting edge; the result must not change.
        if (sgn) begin start_s = 1'b0; x_s = W'($urandom); y_s = W'($urandom); end
        else     begin start_u = 1'b0; x_u = W'($urandom); y_u = W'($urandom); end
        wait_done(sgn, bc, seen);
        check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
        check_eq({tag, "_p"}, 32'(get_p(sgn)), 32'(exp_p));
        check_eq({tag, "_busy_cycles"}, 32'(bc), 32'(ref_busy(sgn, a, b)));
        $display("op %s sgn=%0d x=%h y=%h p=%h exp=%h busy=%0d", tag, sgn, a, b, get_p(sgn), exp_p, bc);
        @(negedge clk);
        check_eq({tag, "_done_drop"}, 32'(get_done(sgn)), 32'd0);
        check_eq({tag, "_p_hold"}, 32'(get_p(sgn)), 32'(exp_p));
    endtask

    initial begin
        int bc;
        bit seen;
        bit any_done;
        logic [W-1:0] ra, rb;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_busy_s", 32'(busy_s), 32'd0);
        check_eq("rst_done_s", 32'(done_s), 32'd0);
        check_eq("rst_p_s", 32'(p_s), 32'd0);
        check_eq("rst_busy_u", 32'(busy_u), 32'd0);
        check_eq("rst_done_u", 32'(done_u), 32'd0);
        check_eq("rst_p_u", 32'(p_u), 32'd0);

        run_op(1'b1, 8'd3,  8'hFB, "s1");
        check_eq("s1_value", 32'(p_s), 32'h0000FFF1);
        run_op(1'b1, 8'h80, 8'h80, "s2a");
        run_op(1'b1, 8'h80, 8'h7F, "s2b");
        run_op(1'b1, 8'hFF, 8'hFF, "s2c");
        run_op(1'b0, 8'hFF, 8'hFF, "s3a");
        check_eq("s3a_value", 32'(p_u), 32'h0000FE01);
        run_op(1'b0, 8'h80, 8'h02, "s3b");

        // Second start during busy is ignored.
        @(negedge clk);
        start_s = 1'b1; x_s = 8'd5; y_s = 8'd6;
        @(negedge clk);
        start_s = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start_s = 1'b1; x_s = 8'd7; y_s = 8'd7;
        @(negedge clk);
        start_s = 1'b0;
        wait_done(1'b1, bc, seen);
        check_eq("s4a_done_seen", 32'(seen), 32'd1);
        check_eq("s4a_p", 32'(p_s), 32'h001E);
        any_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy_s || done_s) any_done = 1'b1;
        end
        check_eq("s4a_no_queued_op", 32'(any_done), 32'd0);
        $display("op s4a p=%h", p_s);

        // start held high through done: next op accepted in the done cycle.
        @(negedge clk);
        start_s = 1'b1; x_s = 8'd5; y_s = 8'd6;
        @(negedge clk);
        wait_done(1'b1, bc, seen);
        check_eq("s4b_first_done", 32'(seen), 32'd1);
        check_eq("s4b_first_p", 32'(p_s), 32'h001E);
        x_s = 8'd7; y_s = 8'd7;
        @(negedge clk);
        start_s = 1'b0;
        check_eq("s4b_accepted", 32'(busy_s), 32'd1);
        wait_done(1'b1, bc, seen);
        check_eq("s4b_second_done", 32'(seen), 32'd1);
        check_eq("s4b_second_p", 32'(p_s), 32'h0031);
        check_eq("s4b_second_busy", 32'(bc), 32'd8);
        $display("op s4b p=%h busy=%0d", p_s, bc);

        // Reset in the 4th busy cycle discards the operation.
        @(negedge clk);
        start_s = 1'b1; x_s = 8'd9; y_s = 8'd9;
        @(negedge clk);
        start_s = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("s5_busy", 32'(busy_s), 32'd0);
        check_eq("s5_done", 32'(done_s), 32'd0);
        check_eq("s5_p", 32'(p_s), 32'd0);
        any_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_s || busy_s) any_done = 1'b1;
        end
        check_eq("s5_no_done", 32'(any_done), 32'd0);
        $display("op s5 reset mid-op p=%h", p_s);
        run_op(1'b1, 8'd2, 8'd3, "s5_after");

        run_op(1'b1, 8'h00, 8'h55, "s6_s");
        run_op(1'b0, 8'h00, 8'h55, "s6_u");
        run_op(1'b1, 8'h37, 8'h00, "s6_s_y0");

        for (int i = 0; i < 60; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 7))
                0: ra = 8'h80;
                1: rb = 8'hFF;
                2: ra = 8'h7F;
                3: rb = 8'h00;
                default: ;
            endcase
            run_op(i[0], ra, rb, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
